// File: rtl/jam_cost_server.sv
// Cost-table responder for the assignment solver: streams in an 8x8 cost table,
// serves W/J lookups with one-cycle latency, then captures and grades the result.
module jam_cost_server #(
   parameter int COST_W  = 7,
   parameter int TIMEOUT = 45000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [COST_W-1:0] load_data,
   input  logic [2:0]        W,
   input  logic [2:0]        J,
   output logic [COST_W-1:0] Cost,
   input  logic [9:0]        MinCost,
   input  logic [3:0]        MatchCount,
   input  logic              Valid,
   input  logic [9:0]        exp_min_cost,
   input  logic [3:0]        exp_match_count,
   output logic              table_loaded,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [9:0]        cap_min_cost,
   output logic [3:0]        cap_match_count
);

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_MAX  = {TO_W{1'b1}};

   typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [5:0]        idx_q, idx_d;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic [COST_W-1:0] cost_q, cost_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [9:0]        cap_min_q, cap_min_d;
   logic [3:0]        cap_cnt_q, cap_cnt_d;
   logic              wr_en;
   logic [COST_W-1:0] table_q [64];

   // Table must clear on reset so a stale table can never be served after a reload abort.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 64; i++) table_q[i] <= '0;
      end else if (wr_en) begin
         table_q[idx_q] <= load_data;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_LOAD;
         idx_q     <= '0;
         cnt_q     <= '0;
         cost_q    <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         cap_min_q <= '0;
         cap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         cost_q    <= cost_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         cap_min_q <= cap_min_d;
         cap_cnt_q <= cap_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      cost_d    = '0;
      done_d    = done_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      cap_min_d = cap_min_q;
      cap_cnt_d = cap_cnt_q;
      wr_en     = 1'b0;
      case (state_q)
         S_LOAD: begin
            cnt_d = '0;
            if (load_valid) begin
               wr_en = 1'b1;
               idx_d = idx_q + 6'd1;
               if (idx_q == 6'd63) state_d = S_SERVE;
            end
         end
         S_SERVE: begin
            cost_d = table_q[{W, J}];
            if (cnt_q != TO_MAX) cnt_d = cnt_q + TO_W'(1);
            // A result arriving on the last allowed cycle still counts as on time.
            if (Valid) begin
               cap_min_d = MinCost;
               cap_cnt_d = MatchCount;
               pass_d    = (MinCost == exp_min_cost) && (MatchCount == exp_match_count);
               done_d    = 1'b1;
               state_d   = S_DONE;
            end else if (cnt_q >= TO_LAST) begin
               timeout_d = 1'b1;
               done_d    = 1'b1;
               pass_d    = 1'b0;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            cost_d = table_q[{W, J}];
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   assign load_ready      = (state_q == S_LOAD);
   assign table_loaded    = (state_q != S_LOAD);
   assign Cost            = cost_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign timeout         = timeout_q;
   assign cap_min_cost    = cap_min_q;
   assign cap_match_count = cap_cnt_q;

endmodule

// File: doc/jam_cost_server.md
Name: jam_cost_server

Overview:
- Responder end of the worker/job cost-matrix read interface: holds the 8x8 cost table and answers the assignment solver's W/J address stream with Cost, one cycle later.
- Collects the solver's final MinCost/MatchCount when Valid rises, compares them against expected values and reports pass/fail/timeout.
- Sits beside the solver in the top-level harness. The 64-entry table is loaded first through a valid/ready stream.

Parameters:
COST_W, 7, width of one cost entry and of Cost
TIMEOUT, 45000, max CLK cycles in SERVE before declaring timeout (covers 8! = 40320 permutations + load + margin)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
load_valid  input  1  load word present
load_ready  output  1  server accepts load word
load_data  input  COST_W  cost word, row-major: k-th accepted word -> table[W=k[5:3]][J=k[2:0]]
W  input  3  worker index from solver
J  input  3  job index from solver
Cost  output  COST_W  table[W][J] of previous cycle
MinCost  input  10  solver result
MatchCount  input  4  solver result
Valid  input  1  solver result valid
exp_min_cost  input  10  expected MinCost, sampled at capture
exp_match_count  input  4  expected MatchCount, sampled at capture
table_loaded  output  1  high from entering SERVE until reset
done  output  1  result captured or timeout
pass  output  1  captured results equal expected
timeout  output  1  TIMEOUT expired without Valid
cap_min_cost  output  10  captured MinCost
cap_match_count  output  4  captured MatchCount

Behaviour:
- Reset values (RST high, async):
  - state = LOAD; load index = 0; table entries = 0; timeout counter = 0.
  - load_ready = 1; Cost = 0; table_loaded = done = pass = timeout = 0; cap_* = 0.
- States LOAD -> SERVE -> DONE. DONE is left only by RST.
- LOAD:
  - load_ready = 1. A word transfers when load_valid && load_ready at a rising edge: written to table[idx[5:3]][idx[2:0]], then idx increments (6-bit).
  - The transfer of word 63 moves the state to SERVE at that edge, and load_ready drops the following cycle.
  - Cost is held at 0. Valid is ignored.
- SERVE:
  - load_ready = 0; table_loaded = 1.
  - Every cycle, Cost <= table[W][J]: a registered read with 1-cycle latency. W/J driven in cycle n appear on Cost in cycle n+1. This matches the solver, which samples Cost against the address it drove the previous cycle.
  - Timeout counter starts at 0 on SERVE entry and increments each cycle. Width is ceil(log2(TIMEOUT+1)) bits, saturating.
  - If Valid = 1 at an edge:
    - cap_min_cost <= MinCost; cap_match_count <= MatchCount.
    - pass <= (MinCost == exp_min_cost) && (MatchCount == exp_match_count).
    - done <= 1; go to DONE.
  - Else, if the counter has reached TIMEOUT-1: timeout <= 1, done <= 1, pass <= 0, go to DONE.
  - Valid and timeout in the same cycle: Valid wins, timeout stays 0.
- DONE:
  - All result outputs hold. Cost keeps serving table[W][J] with 1-cycle latency, so a solver still reading stays consistent.
  - load_valid, Valid and exp_* are ignored.
- Arithmetic: equality compare only. No modification of costs; table values are stored exactly as loaded.
- Reset mid-operation (any state): everything returns to reset values, including the table contents, so a reload is required.

Test Plan:
- Load 64 words k -> value k[5:3]*8+k[2:0] (0..63 truncated to 7 bits) with load_valid held high -> load_ready low on the cycle after the 64th transfer, table_loaded = 1. Drive W=3, J=5 -> Cost = 29 on the next cycle; W=7, J=7 -> Cost = 63.
- load_valid toggling 1,0,1,... during load -> exactly 64 transfers, SERVE entered after the 64th. A word presented after that is not accepted (load_ready = 0).
- In SERVE, change W/J every cycle through all 64 addresses -> each Cost equals the entry addressed one cycle earlier, with no bubbles.
- Pulse Valid with MinCost=290, MatchCount=3, exp 290/3 -> done = 1, pass = 1, cap_min_cost = 290, cap_match_count = 3. Repeat with exp_match_count = 4 -> done = 1, pass = 0.
- Never assert Valid with TIMEOUT = 100 -> done = 1 and timeout = 1 after exactly 100 SERVE cycles. Assert Valid on that same final cycle -> pass/capture taken, timeout = 0.
- Assert RST after 30 load words -> load_ready = 1, Cost = 0, all flags 0. A full 64-word reload behaves as in the first scenario.
